// File: rtl/adder_share_arb.sv
// Round-robin arbiter/sequencer sharing one external combinational adder among NREQ requesters.
// One operation runs at a time: accept (IDLE) -> adder settles (ISSUE) -> hold result (RESP).
module adder_share_arb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH:0]        add_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH:0]        rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           ops_done
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH:0]    rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [15:0]       ops_done_q, ops_done_d;

    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    logic [IDW:0]      scan_idx;
    logic [IDW-1:0]    cand;

    // Scan req_valid from ptr upward with wrap; the first set bit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(off);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            cand = scan_idx[IDW-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == StIdle && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_id_d   = rsp_id_q;
        ops_done_d = ops_done_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d = StIssue;
                    add_a_d = req_a[32'(grant_idx) * WIDTH +: WIDTH];
                    add_b_d = req_b[32'(grant_idx) * WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
                end
            end
            StIssue: begin
                state_d   = StResp;
                rsp_sum_d = add_sum;
                rsp_id_d  = id_q;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d    = StIdle;
                    ops_done_d = ops_done_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        rsp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            id_q        <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: reset, single ops, fairness, backpressure, counter wrap.
module tb_adder_share_arb;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH:0]        add_sum;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH:0]        rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           ops_done;

    int n_checks;
    int n_fail;
    int cyc;
    int last_cyc;
    int wait_cnt;
    logic [16:0] held_sum;
    logic [1:0]  held_id;

    // Stand-in for the external shared adder.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    adder_share_arb #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_id   (rsp_id),
        .ops_done (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Starts in an IDLE cycle just after a negedge, with rsp_ready high; ends in the next IDLE.
    task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] exp_sum);
        req_valid = 4'(1 << i);
        set_ops(i, a, b);
        #1;
        check_eq("op_grant", 32'(req_ready), 32'(1 << i));
        tick();
        req_valid = '0;
        check_eq("op_issue_valid", 32'(rsp_valid), 32'd0);
        check_eq("op_add_a", 32'(add_a), 32'(a));
        check_eq("op_add_b", 32'(add_b), 32'(b));
        tick();
        check_eq("op_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("op_rsp_sum", 32'(rsp_sum), 32'(exp_sum));
        check_eq("op_rsp_id", 32'(rsp_id), 32'(i));
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'h0003);
        tick();
        tick();
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_sum", 32'(rsp_sum), 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        check_eq("rst_ops", 32'(ops_done), 32'd0);
        check_eq("rst_add_a", 32'(add_a), 32'd0);
        check_eq("rst_add_b", 32'(add_b), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single op with carry-out; ptr becomes 2.
        do_op(1, 16'hFFFF, 16'h0001, 17'h10000);
        check_eq("single_ops", 32'(ops_done), 32'd1);

        // Max and zero sums.
        do_op(0, 16'hFFFF, 16'hFFFF, 17'h1FFFE);
        do_op(3, 16'h0000, 16'h0000, 17'h00000);
        check_eq("sums_ops", 32'(ops_done), 32'd3);

        // Fairness: ptr is 0 here, all four requesting continuously.
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i), 16'h0010);
        req_valid = '1;
        last_cyc  = 0;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_cnt = 0;
            while (req_ready == '0 && wait_cnt < 8) begin
                tick();
                wait_cnt++;
            end
            check_eq("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
            if (k > 0) check_eq("fair_gap", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            wait_cnt = 0;
            do begin
                tick();
                wait_cnt++;
            end while (!rsp_valid && wait_cnt < 8);
            check_eq("fair_sum", 32'(rsp_sum), 32'h10 + 32'(k % 4));
            check_eq("fair_id", 32'(rsp_id), 32'(k % 4));
        end
        req_valid = '0;
        tick();
        check_eq("fair_ops", 32'(ops_done), 32'd8);

        // Backpressure: ptr is 1; req 1 served, req 3 waits through a 5-cycle stall.
        rsp_ready = 1'b0;
        set_ops(1, 16'h1234, 16'h1111);
        set_ops(3, 16'h0F0F, 16'h0101);
        req_valid = 4'b0010;
        #1;
        check_eq("bp_grant1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b1000;
        tick();
        check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp_rsp_sum", 32'(rsp_sum), 32'h2345);
        held_sum = rsp_sum;
        held_id  = rsp_id;
        for (int s = 0; s < 5; s++) begin
            tick();
            check_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_hold_sum", 32'(rsp_sum), 32'(held_sum));
            check_eq("bp_hold_id", 32'(rsp_id), 32'(held_id));
            check_eq("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        check_eq("bp_id1", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_grant3", 32'(req_ready), 32'b1000);
        check_eq("bp_ops", 32'(ops_done), 32'd9);
        tick();
        req_valid = '0;
        check_eq("bp_issue", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("bp_sum3", 32'(rsp_sum), 32'h1010);
        check_eq("bp_rid3", 32'(rsp_id), 32'd3);
        tick();
        check_eq("bp_ops2", 32'(ops_done), 32'd10);

        // Reset while stalled in RESP; ptr is 0 afterwards.
        rsp_ready = 1'b0;
        set_ops(0, 16'h0005, 16'h0006);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        check_eq("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        rst_n     = 1'b0;
        set_ops(2, 16'h0007, 16'h0008);
        req_valid = 4'b0100;
        #1;
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        check_eq("mid_rst_ops", 32'(ops_done), 32'd0);
        tick();
        check_eq("mid_rst_ready2", 32'(req_ready), 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check_eq("post_rst_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        check_eq("post_rst_issue", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("post_rst_sum", 32'(rsp_sum), 32'h000F);
        check_eq("post_rst_id", 32'(rsp_id), 32'd2);
        tick();
        check_eq("post_rst_ops", 32'(ops_done), 32'd1);

        // Counter wrap: preload 0xFFFF while idle, then one more op.
        force dut.ops_done_q = 16'hFFFF;
        tick();
        release dut.ops_done_q;
        #1;
        check_eq("wrap_pre", 32'(ops_done), 32'hFFFF);
        do_op(1, 16'h0002, 16'h0003, 17'h00005);
        check_eq("wrap_ops", 32'(ops_done), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
